// File: rtl/axi_sram_bridge_if.sv
// AXI3 channel bundle between the SRAM-like bridge (master) and the interconnect (slave).
interface axi_sram_bridge_if #(
  parameter int unsigned ID_W = 4
);
  // AR channel
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;
  // R channel
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  // AW channel
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [1:0]      awlock;
  logic [3:0]      awcache;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;
  // W channel
  logic [ID_W-1:0] wid;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  // B channel
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_sram_bridge.sv
// Bridges an instruction (read-only) and a data SRAM-like port onto one AXI3 master.
// Reads share a single AR slot with data priority; writes are single-beat and strictly one at a time.
module axi_sram_bridge #(
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned ID_W    = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,

  axi_sram_bridge_if.master axi
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
  localparam logic [ID_W-1:0]  ID_INST = ID_W'(0);
  localparam logic [ID_W-1:0]  ID_DATA = ID_W'(1);

  // AR slot
  logic             ar_valid_q, ar_valid_d;
  logic [ID_W-1:0]  ar_id_q,    ar_id_d;
  logic [31:0]      ar_addr_q,  ar_addr_d;
  logic [2:0]       ar_size_q,  ar_size_d;

  // Outstanding read counters
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
  logic [CNT_W-1:0] data_cnt_q, data_cnt_d;

  // Write transaction
  logic             wr_busy_q,  wr_busy_d;
  logic             aw_valid_q, aw_valid_d;
  logic             w_valid_q,  w_valid_d;
  logic             b_seen_q,   b_seen_d;
  logic [31:0]      aw_addr_q,  aw_addr_d;
  logic [2:0]       aw_size_q,  aw_size_d;
  logic [31:0]      w_data_q,   w_data_d;
  logic [3:0]       w_strb_q,   w_strb_d;

  logic             ar_free_c;
  logic             data_rd_fire_c;
  logic             data_wr_fire_c;
  logic             inst_rd_fire_c;
  logic             inst_r_hit_c;
  logic             data_r_hit_c;
  logic             b_hit_c;
  logic             aw_done_c;
  logic             w_done_c;
  logic             b_done_c;
  logic [3:0]       strb_c;

  // Accept / completion qualifiers; everything is gated by resetn so the ports stay quiet in reset.
  always_comb begin
    ar_free_c      = !ar_valid_q || axi.arready;
    data_rd_fire_c = resetn && data_req && !data_wr && ar_free_c &&
                     (data_cnt_q < CNT_MAX) && !wr_busy_q;
    inst_rd_fire_c = resetn && inst_req && ar_free_c &&
                     (inst_cnt_q < CNT_MAX) && !data_rd_fire_c;
    data_wr_fire_c = resetn && data_req && data_wr && !wr_busy_q &&
                     (data_cnt_q == '0) && !(ar_valid_q && (ar_id_q == ID_DATA));
    inst_r_hit_c   = resetn && axi.rvalid && (axi.rid == ID_INST) && (inst_cnt_q != '0);
    data_r_hit_c   = resetn && axi.rvalid && (axi.rid == ID_DATA) && (data_cnt_q != '0);
    b_hit_c        = resetn && axi.bvalid && wr_busy_q && !b_seen_q;
    aw_done_c      = !aw_valid_q || axi.awready;
    w_done_c       = !w_valid_q  || axi.wready;
    b_done_c       = b_seen_q || b_hit_c;
  end

  // Byte strobes for the data write, selected by transfer size and low address bits.
  always_comb begin
    strb_c = 4'b1111;
    case (data_size)
      2'd0:    strb_c = 4'b0001 << data_addr[1:0];
      2'd1:    strb_c = 4'b0011 << {data_addr[1], 1'b0};
      default: strb_c = 4'b1111;
    endcase
  end

  // AR slot and read counters next state
  always_comb begin
    ar_valid_d = ar_valid_q;
    ar_id_d    = ar_id_q;
    ar_addr_d  = ar_addr_q;
    ar_size_d  = ar_size_q;
    if (ar_valid_q && axi.arready) begin
      ar_valid_d = 1'b0;
    end
    if (data_rd_fire_c) begin
      ar_valid_d = 1'b1;
      ar_id_d    = ID_DATA;
      ar_addr_d  = data_addr;
      ar_size_d  = {1'b0, data_size};
    end else if (inst_rd_fire_c) begin
      ar_valid_d = 1'b1;
      ar_id_d    = ID_INST;
      ar_addr_d  = inst_addr;
      ar_size_d  = {1'b0, inst_size};
    end
    inst_cnt_d = inst_cnt_q + CNT_W'(inst_rd_fire_c) - CNT_W'(inst_r_hit_c);
    data_cnt_d = data_cnt_q + CNT_W'(data_rd_fire_c) - CNT_W'(data_r_hit_c);
  end

  // Write path: AW and W retire independently; the write closes once both are done and B was seen.
  always_comb begin
    wr_busy_d  = wr_busy_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_seen_d   = b_seen_q;
    aw_addr_d  = aw_addr_q;
    aw_size_d  = aw_size_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    if (wr_busy_q) begin
      if (aw_valid_q && axi.awready) aw_valid_d = 1'b0;
      if (w_valid_q && axi.wready)   w_valid_d  = 1'b0;
      if (b_hit_c)                   b_seen_d   = 1'b1;
      if (aw_done_c && w_done_c && b_done_c) begin
        wr_busy_d = 1'b0;
        b_seen_d  = 1'b0;
      end
    end
    if (data_wr_fire_c) begin
      wr_busy_d  = 1'b1;
      aw_valid_d = 1'b1;
      w_valid_d  = 1'b1;
      b_seen_d   = 1'b0;
      aw_addr_d  = data_addr;
      aw_size_d  = {1'b0, data_size};
      w_data_d   = data_wdata;
      w_strb_d   = strb_c;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid_q <= 1'b0;
      ar_id_q    <= '0;
      ar_addr_q  <= '0;
      ar_size_q  <= '0;
      inst_cnt_q <= '0;
      data_cnt_q <= '0;
      wr_busy_q  <= 1'b0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_seen_q   <= 1'b0;
      aw_addr_q  <= '0;
      aw_size_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_id_q    <= ar_id_d;
      ar_addr_q  <= ar_addr_d;
      ar_size_q  <= ar_size_d;
      inst_cnt_q <= inst_cnt_d;
      data_cnt_q <= data_cnt_d;
      wr_busy_q  <= wr_busy_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_seen_q   <= b_seen_d;
      aw_addr_q  <= aw_addr_d;
      aw_size_q  <= aw_size_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
    end
  end

  // SRAM-like side: handshakes are same-cycle by protocol.
  assign inst_addr_ok = inst_rd_fire_c;
  assign data_addr_ok = data_rd_fire_c | data_wr_fire_c;
  assign inst_data_ok = inst_r_hit_c;
  assign data_data_ok = data_r_hit_c | b_hit_c;
  assign inst_rdata   = axi.rdata;
  assign data_rdata   = axi.rdata;

  assign axi.arid    = ar_id_q;
  assign axi.araddr  = ar_addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = ar_size_q;
  assign axi.arburst = 2'b01;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'd0;
  assign axi.arprot  = 3'd0;
  assign axi.arvalid = ar_valid_q;
  assign axi.rready  = 1'b1;

  assign axi.awid    = ID_DATA;
  assign axi.awaddr  = aw_addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = aw_size_q;
  assign axi.awburst = 2'b01;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'd0;
  assign axi.awprot  = 3'd0;
  assign axi.awvalid = aw_valid_q;

  assign axi.wid     = ID_DATA;
  assign axi.wdata   = w_data_q;
  assign axi.wstrb   = w_strb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = w_valid_q;
  assign axi.bready  = 1'b1;

  // Inputs with no function in this bridge (read-only inst port, unused response fields).
  logic unused_ok;
  assign unused_ok = ^{inst_wr, inst_wdata, axi.rresp, axi.rlast, axi.bid, axi.bresp};

endmodule
